// File: rtl/bio_ram_rd_frontend.sv
// Four-channel read front end for the 1W/4R BIO RAM: request handshake, 1-cycle read
// latency absorption and a 2-deep response skid FIFO per channel.
// Optional same-cycle write forwarding is compiled in with `define BIO_RDFE_WR_FWD_EN.
module bio_ram_rd_frontend #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid   [4],
  input  logic [ADDR_WIDTH-1:0] req_addr    [4],
  output logic                  req_ready   [4],
  output logic                  rsp_valid   [4],
  output logic [DATA_WIDTH-1:0] rsp_data    [4],
  input  logic                  rsp_ready   [4],
  output logic                  ram_rd_en   [4],
  output logic [ADDR_WIDTH-1:0] ram_rd_addr [4],
  input  logic [DATA_WIDTH-1:0] ram_rd_data [4],
  input  logic                  wr_en,
  input  logic [MASK_WIDTH-1:0] wr_mask,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned NumCh = 4;

`ifdef BIO_RDFE_WR_FWD_EN
  localparam int unsigned LaneWidth = DATA_WIDTH / MASK_WIDTH;
`else
  logic unused_snoop;
  assign unused_snoop = ^{wr_en, wr_mask, wr_addr, wr_data};
`endif

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [1:0]            occupancy;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  rsp_valid_l;
    logic [DATA_WIDTH-1:0] rsp_data_l;
    logic [DATA_WIDTH-1:0] ret_data;

    // Readiness looks only at registered state so it never depends on rsp_ready.
    assign occupancy      = {1'b0, inflight_q} + count_q;
    assign req_ready[c]   = (occupancy < 2'd2);
    assign accept         = req_valid[c] & req_ready[c];
    assign ram_rd_en[c]   = accept;
    assign ram_rd_addr[c] = req_addr[c];

`ifdef BIO_RDFE_WR_FWD_EN
    logic                  fwd_hit_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;
    logic [MASK_WIDTH-1:0] fwd_mask_q;
    logic                  fwd_hit;

    assign fwd_hit = accept & wr_en & (wr_addr == req_addr[c]);

    always_ff @(posedge clk) begin
      if (reset) begin
        fwd_hit_q  <= 1'b0;
        fwd_data_q <= '0;
        fwd_mask_q <= '0;
      end else begin
        fwd_hit_q <= fwd_hit;
        if (fwd_hit) begin
          fwd_data_q <= wr_data;
          fwd_mask_q <= wr_mask;
        end
      end
    end

    // Write-first merge: masked lanes take the snooped write, others keep RAM data.
    always_comb begin
      ret_data = ram_rd_data[c];
      for (int unsigned l = 0; l < MASK_WIDTH; l++) begin
        if (fwd_hit_q && fwd_mask_q[l]) begin
          ret_data[l*LaneWidth +: LaneWidth] = fwd_data_q[l*LaneWidth +: LaneWidth];
        end
      end
    end
`else
    assign ret_data = ram_rd_data[c];
`endif

    always_comb begin
      rsp_valid_l = 1'b0;
      rsp_data_l  = '0;
      push        = 1'b0;
      pop         = 1'b0;
      if (count_q != 2'd0) begin
        rsp_valid_l = 1'b1;
        rsp_data_l  = fifo_q[rd_ptr_q];
        pop         = rsp_ready[c];
        push        = inflight_q;
      end else if (inflight_q) begin
        rsp_valid_l = 1'b1;
        rsp_data_l  = ret_data;
        push        = ~rsp_ready[c];
      end
    end

    assign rsp_valid[c] = rsp_valid_l;
    assign rsp_data[c]  = rsp_data_l;

    always_comb begin
      inflight_d = accept;
      count_d    = count_q + {1'b0, push} - {1'b0, pop};
      wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
    end

    // A read in flight at reset is dropped by clearing inflight.
    always_ff @(posedge clk) begin
      if (reset) begin
        inflight_q <= 1'b0;
        count_q    <= 2'd0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
      end else begin
        inflight_q <= inflight_d;
        count_q    <= count_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        fifo_q[wr_ptr_q] <= ret_data;
      end
    end
  end

endmodule

// File: tb/tb_bio_ram_rd_frontend.sv
// Bench for bio_ram_rd_frontend: behavioural 1W/4R RAM with registered reads and a
// per-channel scoreboard of expected read data.
module tb_bio_ram_rd_frontend;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk;
  logic          reset;
  logic          req_valid   [4];
  logic [AW-1:0] req_addr    [4];
  logic          req_ready   [4];
  logic          rsp_valid   [4];
  logic [DW-1:0] rsp_data    [4];
  logic          rsp_ready   [4];
  logic          ram_rd_en   [4];
  logic [AW-1:0] ram_rd_addr [4];
  logic [DW-1:0] ram_rd_data [4];
  logic          wr_en;
  logic [MW-1:0] wr_mask;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] exp_q [4][$];
  logic [DW-1:0] got_q [4][$];
  int n_checks;
  int n_fail;

  bio_ram_rd_frontend #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MASK_WIDTH(MW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .wr_en      (wr_en),
    .wr_mask    (wr_mask),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5) return 32'hDEADBEEF;
    if (a == 32) return 32'h11111111;
    return 32'hC0DE0000 | DW'(a);
  endfunction

  // RAM model: read-first, one-cycle registered read, byte-masked write.
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (ram_rd_en[c]) ram_rd_data[c] <= mem[ram_rd_addr[c]];
    end
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (wr_en) begin
      for (int l = 0; l < MW; l++) begin
        if (wr_mask[l]) mem[wr_addr][l*8 +: 8] <= wr_data[l*8 +: 8];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 500000", $time);
    $fatal(1);
  end

  task automatic idle_inputs();
    for (int c = 0; c < 4; c++) begin
      req_valid[c] = 1'b0;
      req_addr[c]  = '0;
      rsp_ready[c] = 1'b1;
    end
    wr_en   = 1'b0;
    wr_mask = '0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  // Settle after driving, then log accepted requests and completed responses.
  task automatic advance();
    #1;
    for (int c = 0; c < 4; c++) begin
      if (req_valid[c] && req_ready[c]) exp_q[c].push_back(mem[req_addr[c]]);
      if (rsp_valid[c] && rsp_ready[c]) got_q[c].push_back(rsp_data[c]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    advance();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (req_ready[c] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_req_ready[%0d]: got %b want 1", c, req_ready[c]);
      end
      n_checks++;
      if (rsp_valid[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rsp_valid[%0d]: got %b want 0", c, rsp_valid[c]);
      end
      n_checks++;
      if (rsp_data[c] !== '0) begin
        n_fail++;
        $display("FAIL reset_rsp_data[%0d]: got %h want 0", c, rsp_data[c]);
      end
      n_checks++;
      if (ram_rd_en[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ram_rd_en[%0d]: got %b want 0", c, ram_rd_en[c]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single_read();
    logic [DW-1:0] e, g;
    req_valid[0] = 1'b1;
    req_addr[0]  = 10'h005;
    rsp_ready[0] = 1'b1;
    advance();
    n_checks++;
    if (ram_rd_en[0] !== 1'b1 || ram_rd_addr[0] !== 10'h005) begin
      n_fail++;
      $display("FAIL single_rd_en: got en=%b addr=%h want en=1 addr=005",
               ram_rd_en[0], ram_rd_addr[0]);
    end
    n_checks++;
    if (rsp_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_valid: got %b want 0", rsp_valid[0]);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    advance();
    n_checks++;
    if (ram_rd_en[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rd_en_pulse: got %b want 0", ram_rd_en[0]);
    end
    n_checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_rsp: got valid=%b data=%h want valid=1 data=deadbeef",
               rsp_valid[0], rsp_data[0]);
    end
    n_checks++;
    if (got_q[0].size() != 1 || exp_q[0].size() != 1) begin
      n_fail++;
      $display("FAIL single_sb_count: got %0d/%0d want 1/1", got_q[0].size(), exp_q[0].size());
    end else begin
      g = got_q[0].pop_front();
      e = exp_q[0].pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL single_sb_data: got %h want %h", g, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e, g;
    rsp_ready[2] = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      req_valid[2] = (i < 16);
      req_addr[2]  = AW'(16 + i);
      advance();
      if (i < 16) begin
        n_checks++;
        if (req_ready[2] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_req_ready cycle %0d: got %b want 1", i, req_ready[2]);
        end
      end
      if (i > 0) begin
        n_checks++;
        if (got_q[2].size() != 1 || exp_q[2].size() == 0) begin
          n_fail++;
          $display("FAIL b2b_rsp_count cycle %0d: got %0d responses want 1", i, got_q[2].size());
          got_q[2].delete();
        end else begin
          g = got_q[2].pop_front();
          e = exp_q[2].pop_front();
          n_checks++;
          if (g !== e || e !== (32'hC0DE0000 | DW'(15 + i))) begin
            n_fail++;
            $display("FAIL b2b_rsp_data cycle %0d: got %h want %h", i, g, e);
          end
        end
      end
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e, g;
    logic v_tab [7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic rr_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic rdy_tab [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      req_valid[1] = v_tab[i];
      req_addr[1]  = AW'(1 + i);
      rsp_ready[1] = rr_tab[i];
      advance();
      n_checks++;
      if (req_ready[1] !== rdy_tab[i]) begin
        n_fail++;
        $display("FAIL bp_req_ready cycle %0d: got %b want %b", i, req_ready[1], rdy_tab[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== (32'hC0DE0000 | 32'h1)) begin
          n_fail++;
          $display("FAIL bp_held_head: got valid=%b data=%h want valid=1 data=c0de0001",
                   rsp_valid[1], rsp_data[1]);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (got_q[1].size() != 2 || exp_q[1].size() != 2) begin
      n_fail++;
      $display("FAIL bp_sb_count: got %0d/%0d want 2/2", got_q[1].size(), exp_q[1].size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        g = got_q[1].pop_front();
        e = exp_q[1].pop_front();
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL bp_sb_data[%0d]: got %h want %h", k, g, e);
        end
      end
    end
    got_q[1].delete();
    exp_q[1].delete();
    rsp_ready[1] = 1'b1;
  endtask

`ifdef BIO_RDFE_WR_FWD_EN
  task automatic test_forwarding();
    logic [DW-1:0] e, g;
    wr_en        = 1'b1;
    wr_mask      = 4'b0101;
    wr_addr      = 10'h020;
    wr_data      = 32'hAABBCCDD;
    req_valid[3] = 1'b1;
    req_addr[3]  = 10'h020;
    rsp_ready[3] = 1'b1;
    advance();
    if (exp_q[3].size() != 0) void'(exp_q[3].pop_back());
    exp_q[3].push_back(32'h11BB11DD);
    @(negedge clk);
    wr_en        = 1'b0;
    req_valid[3] = 1'b0;
    advance();
    n_checks++;
    if (got_q[3].size() != 1) begin
      n_fail++;
      $display("FAIL fwd_rsp_count: got %0d want 1", got_q[3].size());
    end else begin
      g = got_q[3].pop_front();
      e = exp_q[3].pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL fwd_rsp_data: got %h want %h", g, e);
      end
    end
    got_q[3].delete();
    exp_q[3].delete();
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_inflight();
    req_valid[0] = 1'b1;
    req_addr[0]  = 10'h007;
    rsp_ready[0] = 1'b0;
    advance();
    n_checks++;
    if (ram_rd_en[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_inflight_accept: got %b want 1", ram_rd_en[0]);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset        = 1'b1;
    advance();
    @(negedge clk);
    reset = 1'b0;
    exp_q[0].delete();
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance();
      n_checks++;
      if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_inflight cycle %0d: got valid=%b ready=%b want valid=0 ready=1",
                 i, rsp_valid[0], req_ready[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (got_q[c].size() != 0 || exp_q[c].size() != 0) begin
        n_fail++;
        $display("FAIL drain[%0d]: got %0d unmatched responses %0d pending want 0/0",
                 c, got_q[c].size(), exp_q[c].size());
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
`ifdef BIO_RDFE_WR_FWD_EN
    test_forwarding();
`endif
    test_reset_inflight();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bio_ram_rd_frontend.md
# bio_ram_rd_frontend

Four-channel read front end that sits directly upstream of the shared 1-write/4-read-port BIO RAM. It turns each core's valid/ready read request into a single-cycle RAM read-enable pulse, absorbs the RAM's one-cycle registered read latency, and delivers each result on a per-channel valid/ready response channel with backpressure. An optional write-snoop path forwards same-cycle writes, so a read racing a write to the same word returns the new data.

## Interface
Parameters:
- ADDR_WIDTH, 10, word address width; equals RAM wrAddressWidth/rdAddressWidth
- DATA_WIDTH, 32, word width; equals RAM wrDataWidth/rdDataWidth
- MASK_WIDTH, 4, write-mask lanes; lane size = DATA_WIDTH/MASK_WIDTH

Ports (arrays are unpacked [4], index = channel):
- clk  in  1  single clock; also drives RAM wr_clk and rd_clk
- reset  in  1  synchronous, active-high reset
- req_valid[4]  in  1  read request valid
- req_addr[4]  in  ADDR_WIDTH  read word address
- req_ready[4]  out  1  request accepted when valid & ready
- rsp_valid[4]  out  1  response valid
- rsp_data[4]  out  DATA_WIDTH  read data
- rsp_ready[4]  in  1  consumer accepts response
- ram_rd_en[4]  out  1  to RAM rd_en
- ram_rd_addr[4]  out  ADDR_WIDTH  to RAM rd_addr
- ram_rd_data[4]  in  DATA_WIDTH  from RAM rd_data
- wr_en, wr_mask, wr_addr, wr_data  in  1/MASK_WIDTH/ADDR_WIDTH/DATA_WIDTH  snoop of the RAM write port (used only when forwarding is compiled in)

## Operation
The four channels are fully independent and have no arbitration. Each channel holds the following state:
- inflight: 1 bit
- 2-entry response FIFO with count 0..2
- occupancy = inflight + count

Request side:
- req_ready = (occupancy < 2). It depends only on registered state, never on rsp_ready.
- Accept = req_valid & req_ready. On accept: ram_rd_en = 1, ram_rd_addr = req_addr (combinational), and inflight is set for the next cycle.
- When there is no accept, ram_rd_en = 0 and ram_rd_addr = req_addr.

Response side:
- If inflight and count==0: pass-through, with rsp_valid = 1 and rsp_data = ram_rd_data. If rsp_ready is low, the word is pushed into the FIFO.
- If count>0: rsp_valid = 1 and rsp_data = FIFO head. rsp_ready pops the head. A simultaneous inflight word is pushed.
- If inflight and count==2: this state is unreachable, because occupancy never exceeds 2.
- Otherwise rsp_valid = 0 and rsp_data = 0.

Ordering and rates:
- Responses return in request order per channel.
- Sustained throughput is 1 response per cycle per channel when rsp_ready is held high.

Reset:
- Clears inflight, FIFO pointers and count.
- A read in flight when reset is asserted is discarded; its RAM data is ignored.

Reset values of outputs:
- req_ready = 1, rsp_valid = 0, rsp_data = 0, ram_rd_en = 0.

## Timing
- Request accepted in cycle N → RAM samples the request at the posedge ending N → rsp_valid high in cycle N+1 (pass-through case).
- Minimum request-to-response latency is 1 cycle. With backpressure, the response waits in the FIFO.
- Two accepts without any pop (cycles N, N+1) fill the channel: req_ready = 0 from cycle N+2 until a pop.
- A pop in cycle M makes req_ready = 1 in cycle M+1.
- A push and a pop in the same cycle leave count unchanged.

## Configuration
Macro: BIO_RDFE_WR_FWD_EN.

When defined:
- On accept in cycle N with wr_en=1 and wr_addr==req_addr, the frontend registers wr_data and wr_mask.
- In cycle N+1 the returned word takes wr_data in each lane whose mask bit is set, and ram_rd_data elsewhere.
- This merge applies to pass-through and FIFO-push alike, so it gives write-first semantics.

When undefined:
- The snoop inputs are unused.
- A same-cycle same-address read returns RAM data, which is undefined per the RAM's dontCare read-under-write. Benches must not check that value.

## Test plan
- Reset, then idle → req_ready[0..3] = 1, rsp_valid = 0, ram_rd_en = 0.
- Channel 0 reads addr 0x005 (RAM holds 0xDEADBEEF) at cycle N, rsp_ready = 1 → ram_rd_en[0] pulses in N, rsp_valid[0] = 1 with 0xDEADBEEF in N+1.
- Channel 2 issues back-to-back reads 0x010..0x01F with rsp_ready held high → 16 in-order responses on consecutive cycles and req_ready never drops.
- Channel 1: rsp_ready = 0, requests to 0x001 and 0x002 → req_ready[1] = 0 from the third cycle. Raise rsp_ready → data for 0x001 then 0x002, and req_ready returns the cycle after the first pop.
- With forwarding compiled in: RAM[0x020] = 0x11111111; in the same cycle, write 0xAABBCCDD with mask 4'b0101 and read 0x020 on channel 3 → response 0x11BB11DD.
- Reset asserted the cycle after an accept on channel 0 → no rsp_valid[0] after reset, and req_ready[0] = 1.
